gate_bist: RTL and testbench

- Self-test sequencer for the two-input logic-gate block (inputs a, b; outputs and, or, not_a, xor, xnor, nand).
- Drives the gate block's a/b inputs through every input combination.
- Samples all six gate outputs after a programmable settle time and compares them against an internally computed truth table.
- Reports sticky per-gate fail flags, a saturating error count and a pass/done result.

---
 rtl/gate_bist.sv | 110 +++++++++++
 tb/tb_gate_bist.sv | 139 +++++++++++++
 2 files changed

// File: rtl/gate_bist.sv
// gate_bist: self-test sequencer for a two-input logic-gate block.
//   Parameters: SETTLE_CYCLES (idle cycles between drive and sample), PASSES (4-vector sweeps per run),
//               CNT_W (error counter width).
//   Ports: clk, rst_n (async active-low); start (run request, sampled in IDLE);
//          a_o/b_o drive the gate block; and_i..nand_i are its six outputs;
//          busy (not IDLE), done (1-cycle end pulse), pass (result, held until next start),
//          fail_mask (sticky per-gate flags: and,or,not_a,xor,xnor,nand = bit0..5),
//          err_cnt (saturating count of mismatching gate samples).
module gate_bist #(
  parameter int SETTLE_CYCLES = 1,
  parameter int PASSES        = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_o,
  output logic             b_o,
  input  logic             and_i,
  input  logic             or_i,
  input  logic             not_a_i,
  input  logic             xor_i,
  input  logic             xnor_i,
  input  logic             nand_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [5:0]       fail_mask,
  output logic [CNT_W-1:0] err_cnt
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DRIVE  = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] SAMPLE = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;
  localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int PW = $clog2(PASSES + 1);
  logic [2:0]       state, nxt;
  logic [1:0]       vec;
  logic [PW-1:0]    sweep;
  logic [SW-1:0]    cnt;
  logic [5:0]       expected, mismatch, new_mask;
  logic [2:0]       pop;
  logic [CNT_W+2:0] sum;
  logic [CNT_W-1:0] sat;
  logic             last;
  always_comb begin
    expected = {~(a_o & b_o), ~(a_o ^ b_o), a_o ^ b_o, ~a_o, a_o | b_o, a_o & b_o};
    mismatch = expected ^ {nand_i, xnor_i, xor_i, not_a_i, or_i, and_i};
    new_mask = fail_mask | mismatch;
    pop = 3'(mismatch[0]) + 3'(mismatch[1]) + 3'(mismatch[2])
        + 3'(mismatch[3]) + 3'(mismatch[4]) + 3'(mismatch[5]);
    sum = (CNT_W+3)'(err_cnt) + (CNT_W+3)'(pop);
    // clamp at all-ones instead of wrapping
    sat = sum > (CNT_W+3)'({CNT_W{1'b1}}) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    last = vec == 2'd3 && sweep == PW'(PASSES - 1);
    nxt = IDLE;
    unique case (state)
      IDLE:    nxt = start ? DRIVE : IDLE;
      DRIVE:   nxt = SETTLE_CYCLES == 0 ? SAMPLE : SETTLE;
      SETTLE:  nxt = cnt == SW'(1) ? SAMPLE : SETTLE;
      SAMPLE:  nxt = last ? DONE : DRIVE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_o       <= 1'b0;
      b_o       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= '0;
      err_cnt   <= '0;
      vec       <= '0;
      sweep     <= '0;
      cnt       <= '0;
    end else begin
      state <= nxt;
      busy  <= nxt != IDLE;
      done  <= nxt == DONE;
      unique case (state)
        IDLE: if (start) begin
          pass      <= 1'b0;
          fail_mask <= '0;
          err_cnt   <= '0;
          vec       <= '0;
          sweep     <= '0;
          a_o       <= 1'b0;
          b_o       <= 1'b0;
        end
        DRIVE:  cnt <= SW'(SETTLE_CYCLES);
        SETTLE: cnt <= cnt - SW'(1);
        SAMPLE: begin
          fail_mask <= new_mask;
          err_cnt   <= sat;
          vec       <= vec + 2'd1;
          if (vec == 2'd3) sweep <= sweep + PW'(1);
          // the next vector appears on a_o/b_o as DRIVE is entered; after the last sample they hold
          if (!last) {a_o, b_o} <= vec + 2'd1;
          // pass sees the final sample's mismatches on the same edge that records them
          if (last) pass <= new_mask == 6'h00;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gate_bist.sv
// tb_gate_bist: table-driven scoreboard bench for gate_bist across three parameter sets.
module tb_gate_bist;
  typedef struct {
    int         d;
    logic [5:0] inv, f0, f1, fm;
    int         ec;
    logic       ps;
    int         lat;
    bit         poke;
  } vec_t;
  localparam int ST[3] = '{1, 0, 1};
  localparam int PS[3] = '{1, 3, 1};
  logic       clk = 0, rst_n = 0;
  logic       st[3];
  logic       a_w[3], b_w[3], busy_w[3], done_w[3], pass_w[3];
  logic [5:0] fm_w[3], g[3], inv[3], f0[3], f1[3];
  logic [7:0] ec0, ec1;
  logic [3:0] ec2;
  vec_t       tbl[9];
  vec_t       sb[$];
  int         n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  function automatic logic [5:0] gold(logic a, logic b);
    return {~(a & b), ~(a ^ b), a ^ b, ~a, a | b, a & b};
  endfunction
  always_comb for (int i = 0; i < 3; i++) g[i] = ((gold(a_w[i], b_w[i]) ^ inv[i]) & ~f0[i]) | f1[i];
  gate_bist u0 (.clk(clk), .rst_n(rst_n), .start(st[0]), .a_o(a_w[0]), .b_o(b_w[0]),
    .and_i(g[0][0]), .or_i(g[0][1]), .not_a_i(g[0][2]), .xor_i(g[0][3]), .xnor_i(g[0][4]), .nand_i(g[0][5]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .fail_mask(fm_w[0]), .err_cnt(ec0));
  gate_bist #(.SETTLE_CYCLES(0), .PASSES(3)) u1 (.clk(clk), .rst_n(rst_n), .start(st[1]), .a_o(a_w[1]), .b_o(b_w[1]),
    .and_i(g[1][0]), .or_i(g[1][1]), .not_a_i(g[1][2]), .xor_i(g[1][3]), .xnor_i(g[1][4]), .nand_i(g[1][5]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .fail_mask(fm_w[1]), .err_cnt(ec1));
  gate_bist #(.CNT_W(4)) u2 (.clk(clk), .rst_n(rst_n), .start(st[2]), .a_o(a_w[2]), .b_o(b_w[2]),
    .and_i(g[2][0]), .or_i(g[2][1]), .not_a_i(g[2][2]), .xor_i(g[2][3]), .xnor_i(g[2][4]), .nand_i(g[2][5]),
    .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .fail_mask(fm_w[2]), .err_cnt(ec2));
  function automatic int ecv(int d);
    return d == 0 ? int'(ec0) : d == 1 ? int'(ec1) : int'(ec2);
  endfunction
  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  task automatic run(input vec_t r);
    int   d = r.d;
    int   s = ST[r.d];
    int   n = 4 * PS[r.d] * (ST[r.d] + 2);
    bit   seen = 0;
    vec_t e = r;
    inv[d] = r.inv; f0[d] = r.f0; f1[d] = r.f1;
    @(negedge clk); st[d] = 1; sb.push_back(r);
    for (int k = 1; k <= n + 8 && !seen; k++) begin
      @(negedge clk);
      st[d] = (k == 1) ? r.poke : 1'b0;
      if (k == 1) begin
        chk("busy_at_start", busy_w[d], 1);
        chk("mask_cleared", fm_w[d], 0);
        chk("cnt_cleared", ecv(d), 0);
        chk("pass_cleared", pass_w[d], 0);
      end
      if (k <= n) chk($sformatf("ab_d%0d_k%0d", d, k), {a_w[d], b_w[d]}, ((k - 1) / (s + 2)) % 4);
      if (done_w[d]) begin
        seen = 1;
        if (sb.size() == 0) chk("sb_empty", 1, 0);
        else begin
          e = sb.pop_front();
          chk($sformatf("latency_d%0d", d), k, e.lat);
          chk($sformatf("fail_mask_d%0d", d), fm_w[d], e.fm);
          chk($sformatf("err_cnt_d%0d", d), ecv(d), e.ec);
          chk($sformatf("pass_d%0d", d), pass_w[d], e.ps);
          chk("busy_in_done", busy_w[d], 1);
        end
        if (r.poke) st[d] = 1;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(negedge clk); st[d] = 0;
    chk("done_single", done_w[d], 0);
    chk("idle_busy", busy_w[d], 0);
    chk("pass_held", pass_w[d], e.ps);
    @(negedge clk);
    chk("idle_busy2", busy_w[d], 0);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin st[i] = 0; inv[i] = 0; f0[i] = 0; f1[i] = 0; end
    tbl[0] = '{0, 6'h00, 6'h00, 6'h00, 6'h00, 0, 1'b1, 13, 1'b1};
    tbl[1] = '{0, 6'h00, 6'h08, 6'h00, 6'h08, 2, 1'b0, 13, 1'b0};
    tbl[2] = '{0, 6'h00, 6'h00, 6'h00, 6'h00, 0, 1'b1, 13, 1'b0};
    tbl[3] = '{0, 6'h00, 6'h04, 6'h00, 6'h04, 2, 1'b0, 13, 1'b0};
    tbl[4] = '{0, 6'h00, 6'h00, 6'h01, 6'h01, 3, 1'b0, 13, 1'b0};
    tbl[5] = '{1, 6'h00, 6'h00, 6'h20, 6'h20, 3, 1'b0, 25, 1'b0};
    tbl[6] = '{1, 6'h00, 6'h02, 6'h00, 6'h02, 9, 1'b0, 25, 1'b0};
    tbl[7] = '{2, 6'h3F, 6'h00, 6'h00, 6'h3F, 15, 1'b0, 13, 1'b0};
    tbl[8] = '{2, 6'h00, 6'h00, 6'h10, 6'h10, 2, 1'b0, 13, 1'b0};
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_busy", busy_w[d], 0); chk("rst_done", done_w[d], 0); chk("rst_pass", pass_w[d], 0);
      chk("rst_mask", fm_w[d], 0); chk("rst_cnt", ecv(d), 0); chk("rst_ab", {a_w[d], b_w[d]}, 0);
    end
    rst_n = 1;
    for (int i = 0; i < 9; i++) run(tbl[i]);
    // reset during SETTLE of vector 10, after the 01 mismatch has been recorded
    f0[0] = 6'h08; inv[0] = 0; f1[0] = 0;
    @(negedge clk); st[0] = 1;
    @(negedge clk); st[0] = 0;
    repeat (7) @(negedge clk);
    chk("pre_rst_ab", {a_w[0], b_w[0]}, 2);
    chk("pre_rst_cnt", ecv(0), 1);
    rst_n = 0;
    #1;
    chk("mid_rst_busy", busy_w[0], 0); chk("mid_rst_ab", {a_w[0], b_w[0]}, 0);
    chk("mid_rst_mask", fm_w[0], 0); chk("mid_rst_cnt", ecv(0), 0);
    for (int i = 0; i < 4; i++) begin @(negedge clk); chk("mid_rst_done", done_w[0], 0); end
    rst_n = 1;
    run(tbl[2]);
    // start held high: restarts on the first IDLE cycle after DONE
    f0[0] = 0;
    @(negedge clk); st[0] = 1;
    begin
      int k = 0;
      while (!done_w[0] && k < 30) begin @(negedge clk); k++; end
      chk("hold_first_done", k, 13);
      @(negedge clk);
      chk("hold_idle_gap", busy_w[0], 0);
      @(negedge clk); st[0] = 0;
      chk("hold_restart", busy_w[0], 1);
      chk("hold_restart_ab", {a_w[0], b_w[0]}, 0);
      k = 1;
      while (!done_w[0] && k < 30) begin @(negedge clk); k++; end
      chk("hold_second_done", k, 13);
      chk("hold_second_pass", pass_w[0], 1);
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
